// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the multi-port register file.
// Includes the address-width derivation and flattened-bus slicing.
package regfile_pkg;

  localparam int unsigned XLEN_DEF  = 32'd32;
  localparam int unsigned NREGS_DEF = 32'd32;

  // Smallest r with 2**r >= n; used to size register addresses.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 32'd0;
    for (int unsigned i = 32'd0; i < 32'd31; i++) begin
      r = ((32'd1 << i) < n) ? (i + 32'd1) : r;
    end
    return r;
  endfunction

  // Low bit of lane idx in a flattened bus of w-bit lanes.
  function automatic int unsigned slice_lo(input int unsigned idx, input int unsigned w);
    return idx * w;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy scoreboard: tracks outstanding producers.
// Also drives the issue handshake and per-read-port busy flags.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int unsigned NREGS    = NREGS_DEF,
  parameter int unsigned NRP      = 32'd2,
  parameter int unsigned NWP      = 32'd1,
  parameter bit          ZERO_REG = 1'b1,
  parameter bit          BYPASS   = 1'b1,
  localparam int unsigned AW      = clog2(NREGS)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [NRP*AW-1:0] rp_addr,
  input  logic [NWP-1:0]    wp_en,
  input  logic [NWP*AW-1:0] wp_addr,
  input  logic              iss_valid,
  input  logic [AW-1:0]     iss_rd,
  output logic [NRP-1:0]    rp_busy,
  output logic              iss_ready,
  output logic [NREGS-1:0]  busy_vec
);

  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;
  logic [NREGS-1:0] wr_hit_s;
  logic [AW-1:0]    raddr_s [NRP];
  logic             rd_zero_s;
  logic             iss_fire_s;

  // Which registers see an enabled write this cycle
  always_comb begin
    wr_hit_s = {NREGS{1'b0}};
    for (int r = 0; r < NREGS; r++) begin
      for (int j = 0; j < NWP; j++) begin
        wr_hit_s[r] = wr_hit_s[r] |
                      (wp_en[j] && (wp_addr[slice_lo(j, AW) +: AW] == AW'(r)));
      end
    end
  end

  // Issue handshake and next busy state; a set beats a same-cycle clear
  always_comb begin
    rd_zero_s  = ZERO_REG && (iss_rd == {AW{1'b0}});
    iss_ready  = rd_zero_s || !busy_q[iss_rd] || wr_hit_s[iss_rd];
    iss_fire_s = iss_valid && iss_ready;
    busy_d     = busy_q;
    for (int r = 0; r < NREGS; r++) begin
      busy_d[r] = (iss_fire_s && !rd_zero_s && (iss_rd == AW'(r))) ? 1'b1 :
                  (wr_hit_s[r] ? 1'b0 : busy_q[r]);
    end
  end

  // Busy flag seen by each read port
  always_comb begin
    rp_busy = {NRP{1'b0}};
    for (int i = 0; i < NRP; i++) begin
      raddr_s[i] = rp_addr[slice_lo(i, AW) +: AW];
      rp_busy[i] = ((ZERO_REG && (raddr_s[i] == {AW{1'b0}})) ||
                    (BYPASS && wr_hit_s[raddr_s[i]])) ? 1'b0 : busy_q[raddr_s[i]];
    end
  end

  // Scoreboard state
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy_q <= {NREGS{1'b0}};
    end else begin
      busy_q <= busy_d;
    end
  end

  assign busy_vec = busy_q;

endmodule

// File: rtl/regfile_mp_sb.sv
// Multi-port integer register file with write-to-read bypass.
// Storage, write priority and read muxing live here; busy tracking is in regfile_scoreboard.
module regfile_mp_sb
  import regfile_pkg::*;
#(
  parameter int unsigned XLEN     = XLEN_DEF,
  parameter int unsigned NREGS    = NREGS_DEF,
  parameter int unsigned NRP      = 32'd2,
  parameter int unsigned NWP      = 32'd1,
  parameter bit          ZERO_REG = 1'b1,
  parameter bit          BYPASS   = 1'b1,
  localparam int unsigned AW      = clog2(NREGS)
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [NRP*AW-1:0]   rp_addr,
  output logic [NRP*XLEN-1:0] rp_data,
  output logic [NRP-1:0]      rp_busy,
  input  logic [NWP-1:0]      wp_en,
  input  logic [NWP*AW-1:0]   wp_addr,
  input  logic [NWP*XLEN-1:0] wp_data,
  input  logic                iss_valid,
  input  logic [AW-1:0]       iss_rd,
  output logic                iss_ready,
  output logic [NREGS-1:0]    busy_vec
);

  logic [XLEN-1:0] mem_q   [NREGS];
  logic [XLEN-1:0] mem_d   [NREGS];
  logic [AW-1:0]   waddr_s [NWP];
  logic [XLEN-1:0] wdata_s [NWP];
  logic [NWP-1:0]  wkeep_s;
  logic [AW-1:0]   raddr_s [NRP];
  logic [XLEN-1:0] rdata_s [NRP];

  // Unpack write ports; writes to a hardwired x0 are dropped
  always_comb begin
    wkeep_s = {NWP{1'b0}};
    for (int j = 0; j < NWP; j++) begin
      waddr_s[j] = wp_addr[slice_lo(j, AW) +: AW];
      wdata_s[j] = wp_data[slice_lo(j, XLEN) +: XLEN];
      wkeep_s[j] = wp_en[j] && !(ZERO_REG && (waddr_s[j] == {AW{1'b0}}));
    end
  end

  // Next array contents; ascending port order lets the highest port win
  always_comb begin
    for (int r = 0; r < NREGS; r++) begin
      mem_d[r] = mem_q[r];
      for (int j = 0; j < NWP; j++) begin
        mem_d[r] = (wkeep_s[j] && (waddr_s[j] == AW'(r))) ? wdata_s[j] : mem_d[r];
      end
    end
  end

  // Register array
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int r = 0; r < NREGS; r++) begin
        mem_q[r] <= {XLEN{1'b0}};
      end
    end else begin
      for (int r = 0; r < NREGS; r++) begin
        mem_q[r] <= mem_d[r];
      end
    end
  end

  // Read mux: array, then bypass (highest port wins), then x0 override
  always_comb begin
    for (int i = 0; i < NRP; i++) begin
      raddr_s[i] = rp_addr[slice_lo(i, AW) +: AW];
      rdata_s[i] = mem_q[raddr_s[i]];
      for (int j = 0; j < NWP; j++) begin
        rdata_s[i] = (BYPASS && wp_en[j] && (waddr_s[j] == raddr_s[i])) ?
                     wdata_s[j] : rdata_s[i];
      end
      rdata_s[i] = (ZERO_REG && (raddr_s[i] == {AW{1'b0}})) ? {XLEN{1'b0}} : rdata_s[i];
    end
  end

  // Pack read data
  always_comb begin
    rp_data = {(NRP*XLEN){1'b0}};
    for (int i = 0; i < NRP; i++) begin
      rp_data[slice_lo(i, XLEN) +: XLEN] = rdata_s[i];
    end
  end

  regfile_scoreboard #(
    .NREGS    (NREGS),
    .NRP      (NRP),
    .NWP      (NWP),
    .ZERO_REG (ZERO_REG),
    .BYPASS   (BYPASS)
  ) u_scoreboard (
    .clk       (clk),
    .reset_n   (reset_n),
    .rp_addr   (rp_addr),
    .wp_en     (wp_en),
    .wp_addr   (wp_addr),
    .iss_valid (iss_valid),
    .iss_rd    (iss_rd),
    .rp_busy   (rp_busy),
    .iss_ready (iss_ready),
    .busy_vec  (busy_vec)
  );

endmodule

// File: doc/regfile_mp_sb.md
# regfile_mp_sb

Parametrised multi-port integer register file with write-to-read bypass and a per-register busy scoreboard. It is the next-generation register file for the pipelined core and sits between decode/issue (read ports and scoreboard) and writeback (write ports). It keeps the x0-hardwired-zero rule as an option. Its scoreboard lets issue logic stall on RAW hazards without a separate hazard unit.

## Interface
- XLEN, 32, register width in bits
- NREGS, 32, register count (power of 2, ≥ 2); AW = log2(NREGS)
- NRP, 2, read ports (1..4)
- NWP, 1, write ports (1..2)
- ZERO_REG, 1, 1 = register 0 reads zero, ignores writes, never goes busy
- BYPASS, 1, 1 = same-cycle write data forwarded to matching reads
- clk  in  1  clock, all state updates on rising edge
- reset_n  in  1  reset, asynchronous, active-low
- rp_addr  in  NRP*AW  read addresses, port i at [i*AW +: AW]
- rp_data  out  NRP*XLEN  read data, combinational
- rp_busy  out  NRP  scoreboard busy bit for each read address, combinational
- wp_en  in  NWP  write enables
- wp_addr  in  NWP*AW  write addresses
- wp_data  in  NWP*XLEN  write data
- iss_valid  in  1  issue request: mark iss_rd busy
- iss_rd  in  AW  destination register of the issuing instruction
- iss_ready  out  1  issue accepted this cycle when iss_valid && iss_ready
- busy_vec  out  NREGS  full scoreboard state, registered

## Operation
- Storage: NREGS × XLEN array plus busy[NREGS].
- Write: on each edge, every port j with wp_en[j] writes wp_data[j] to wp_addr[j].
  - Two ports writing the same address in one cycle: the higher port index wins.
  - ZERO_REG=1 and addr 0: the write is dropped.
- Read, port i: ZERO_REG && addr==0 gives 0.
  - Otherwise, if BYPASS and some enabled write port targets the address this cycle, the output is that port's wp_data (highest index wins).
  - Otherwise the output is array[addr].
- Scoreboard:
  - Issue handshake fires when iss_valid && iss_ready; busy[iss_rd] is set at the next edge.
  - Any enabled write to r clears busy[r] at the next edge.
  - Set and clear of the same register in one cycle: set wins, so the new producer stays pending.
- iss_ready = !busy[iss_rd] || (an enabled write to iss_rd this cycle). Only one outstanding producer per register is allowed; a second issue to a busy register stalls.
  - ZERO_REG and iss_rd==0: iss_ready=1 and busy is never set.
- rp_busy[i] = busy[addr].
  - When BYPASS=1, it is forced to 0 if a write to addr occurs this cycle, because the data is being forwarded.
  - ZERO_REG and addr 0: always 0.
- Writes to a non-busy register are legal (e.g. CSR/debug path) and still clear nothing extra.

## Timing
- Reset (asynchronous, any time, including mid-write or mid-issue):
  - all registers = 0 and busy = 0
  - busy_vec = 0
  - iss_ready = 1
  - rp_data = 0 and rp_busy = 0 for any address, provided no write is active
- Read latency: 0 cycles, combinational from rp_addr.
- Write-to-read:
  - BYPASS=1: same cycle.
  - BYPASS=0: next cycle; rp_busy stays 1 during the write cycle.
- Issue-to-busy: busy_vec and rp_busy reflect the issue 1 cycle after the handshake.
- Writeback-to-clear: busy_vec clears 1 cycle after the write edge. rp_busy clears in the same cycle only when BYPASS=1.
- Reads, writes and issue on all ports are processed in parallel every cycle; no back-pressure except iss_ready.

## Structure
- Package regfile_pkg holds:
  - the AW derivation function (clog2)
  - default XLEN/NREGS constants
  - the port-slice helper for flattened address/data buses
- One sub-module, regfile_scoreboard: owns busy[], the iss_ready logic and the rp_busy/busy_vec outputs.
- The top level holds the array, the write-priority logic and the bypass mux.

## Test plan
- Reset: write x5=0xDEADBEEF, assert reset_n=0 mid-cycle -> x5 reads 0 immediately, busy_vec=0, iss_ready=1.
- Zero register: ZERO_REG=1, write 0x1234 to x0 and issue iss_rd=0 -> rp_data=0, busy_vec[0]=0, iss_ready=1 throughout.
- Bypass: BYPASS=1, write x7=0xA5A5A5A5 while rp_addr[0]=7 in the same cycle -> rp_data[0]=0xA5A5A5A5 that cycle. With BYPASS=0 the old value appears that cycle and the new value the next.
- Write conflict: NWP=2, both ports write x3 (0x11, 0x22) -> x3=0x22 next cycle; a same-cycle bypass read also returns 0x22.
- Scoreboard stall: issue x9 -> busy_vec[9]=1 next cycle; a second issue of x9 gives iss_ready=0. Writeback x9 plus re-issue in the same cycle gives iss_ready=1, busy_vec[9] stays 1, and x9 holds the written data.
- Random mixed traffic checked against a reference model of the array and busy bits across all parameter corners: NRP 1/4, NWP 1/2, ZERO_REG 0/1, BYPASS 0/1.
